// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle sequencing controller and its datapath.
// The master side is the controller; the slave side is the datapath that
// supplies instruction fields and ALU flags and consumes selects and enables.
// Optional macro CTRL_MEM_WAIT_EN adds the mem_ready handshake input.
interface multicycle_ctrl_if #(
    parameter int ALUCTRL_W = 2,
    parameter int STATE_W   = 4
);
    logic [3:0]           instr_cond;
    logic [1:0]           instr_op;
    logic [5:0]           instr_funct;
    logic [3:0]           instr_rd;
    logic [3:0]           alu_flags;
`ifdef CTRL_MEM_WAIT_EN
    logic                 mem_ready;
`endif
    logic                 pc_write;
    logic                 mem_write;
    logic                 reg_write;
    logic                 ir_write;
    logic                 adr_src;
    logic                 alu_src_a;
    logic [1:0]           alu_src_b;
    logic [1:0]           result_src;
    logic [1:0]           imm_src;
    logic [1:0]           reg_src;
    logic [ALUCTRL_W-1:0] alu_control;
    logic [STATE_W-1:0]   state_o;

    modport master (
        input  instr_cond, instr_op, instr_funct, instr_rd, alu_flags,
`ifdef CTRL_MEM_WAIT_EN
        input  mem_ready,
`endif
        output pc_write, mem_write, reg_write, ir_write, adr_src, alu_src_a,
               alu_src_b, result_src, imm_src, reg_src, alu_control, state_o
    );

    modport slave (
        output instr_cond, instr_op, instr_funct, instr_rd, alu_flags,
`ifdef CTRL_MEM_WAIT_EN
        output mem_ready,
`endif
        input  pc_write, mem_write, reg_write, ir_write, adr_src, alu_src_a,
               alu_src_b, result_src, imm_src, reg_src, alu_control, state_o
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main sequencing controller of the multicycle ARM-subset core.
// Steps the shared datapath through fetch/decode/execute/writeback, holds the
// NZCV flags, evaluates the condition field and decodes the ALU operation.
// Outputs are a Moore decode of the current state, gated by the registered
// condition result. Optional macro CTRL_MEM_WAIT_EN stalls FETCH, MEMREAD and
// MEMWRITE until mem_ready is high.
module multicycle_ctrl #(
    parameter int ALUCTRL_W = 2,
    parameter int STATE_W   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_ctrl_if.master    bus
);
    typedef enum logic [STATE_W-1:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
        S_MEMWRITE, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
    } state_t;

    localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(0);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(2);
    localparam logic [ALUCTRL_W-1:0] ALU_ORR = ALUCTRL_W'(3);

    state_t               state_q, state_d;
    logic [3:0]           flags_q, flags_d;     // {N,Z,C,V}
    logic                 cond_ok_q, cond_ok_d;
    logic                 mem_ready;
    logic [3:0]           cmd;
    logic                 is_cmp, cmd_known, cmd_arith;
    logic [ALUCTRL_W-1:0] alu_dec;

`ifdef CTRL_MEM_WAIT_EN
    assign mem_ready = bus.mem_ready;
`else
    assign mem_ready = 1'b1;
`endif

    assign cmd    = bus.instr_funct[4:1];
    assign is_cmp = (cmd == 4'b1010);

    // ARM condition evaluation against the stored flags; 1111 never executes.
    function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'b0000: cond_check = z;
            4'b0001: cond_check = !z;
            4'b0010: cond_check = c;
            4'b0011: cond_check = !c;
            4'b0100: cond_check = n;
            4'b0101: cond_check = !n;
            4'b0110: cond_check = v;
            4'b0111: cond_check = !v;
            4'b1000: cond_check = c && !z;
            4'b1001: cond_check = !c || z;
            4'b1010: cond_check = (n == v);
            4'b1011: cond_check = (n != v);
            4'b1100: cond_check = !z && (n == v);
            4'b1101: cond_check = z || (n != v);
            4'b1110: cond_check = 1'b1;
            default: cond_check = 1'b0;
        endcase
    endfunction

    // ALU operation decode; unrecognised commands add and never touch flags.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        alu_dec   = ALU_ADD;
        cmd_known = 1'b1;
        cmd_arith = 1'b1;
        case (cmd)
            4'b0100: alu_dec = ALU_ADD;
            4'b0010: alu_dec = ALU_SUB;
            4'b0000: begin alu_dec = ALU_AND; cmd_arith = 1'b0; end
            4'b1100: begin alu_dec = ALU_ORR; cmd_arith = 1'b0; end
            4'b1010: alu_dec = ALU_SUB;
            default: cmd_known = 1'b0;
        endcase
    end

    // Next state, condition latch at DECODE, and flag update at the end of execute.
    always_comb begin
        state_d   = state_q;
        flags_d   = flags_q;
        cond_ok_d = cond_ok_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                cond_ok_d = cond_check(bus.instr_cond, flags_q);
                case (bus.instr_op)
                    2'b01:   state_d = S_MEMADR;
                    2'b00:   state_d = bus.instr_funct[5] ? S_EXECI : S_EXECR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = bus.instr_funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECR, S_EXECI: begin
                state_d = S_ALUWB;
                if (cond_ok_q && cmd_known && (bus.instr_funct[0] || is_cmp)) begin
                    flags_d[3:2] = bus.alu_flags[3:2];
                    if (cmd_arith) flags_d[1:0] = bus.alu_flags[1:0];
                end
            end
            default:    state_d = S_FETCH;
        endcase
    end

    // State, flags and condition result; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            flags_q   <= 4'b0000;
            cond_ok_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            flags_q   <= flags_d;
            cond_ok_q <= cond_ok_d;
        end
    end

    // Per-state datapath selects and enables; writes are gated by cond_ok.
    always_comb begin
        bus.pc_write    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.reg_write   = 1'b0;
        bus.ir_write    = 1'b0;
        bus.adr_src     = 1'b0;
        bus.alu_src_a   = 1'b0;
        bus.alu_src_b   = 2'b00;
        bus.result_src  = 2'b00;
        bus.alu_control = ALU_ADD;
        bus.imm_src     = bus.instr_op;
        bus.reg_src     = {(bus.instr_op == 2'b01) && !bus.instr_funct[0],
                           (bus.instr_op == 2'b10)};
        bus.state_o     = state_q;
        case (state_q)
            S_FETCH: begin
                bus.ir_write   = mem_ready;
                bus.pc_write   = mem_ready;
                bus.alu_src_a  = 1'b1;
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
            end
            S_DECODE: begin
                bus.alu_src_a  = 1'b1;
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
            end
            S_MEMADR:   bus.alu_src_b = 2'b01;
            S_MEMREAD:  bus.adr_src = 1'b1;
            S_MEMWB: begin
                bus.result_src = 2'b01;
                bus.reg_write  = cond_ok_q;
                bus.pc_write   = cond_ok_q && (bus.instr_rd == 4'd15);
            end
            S_MEMWRITE: begin
                bus.adr_src   = 1'b1;
                bus.mem_write = cond_ok_q && mem_ready;
            end
            S_EXECR:    bus.alu_control = alu_dec;
            S_EXECI: begin
                bus.alu_src_b   = 2'b01;
                bus.alu_control = alu_dec;
            end
            S_ALUWB: begin
                // CMP only produces flags: neither the register file nor the PC is written.
                bus.reg_write = cond_ok_q && !is_cmp;
                bus.pc_write  = cond_ok_q && !is_cmp && (bus.instr_rd == 4'd15);
            end
            S_BRANCH: begin
                bus.alu_src_b  = 2'b01;
                bus.result_src = 2'b10;
                bus.pc_write   = cond_ok_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. A model derives the state sequence
// of each instruction from its class, tracks NZCV and the condition result,
// and a single negedge process compares all outputs every cycle. Literal
// expectations pin latencies and key enables. Honours CTRL_MEM_WAIT_EN.
`timescale 1ns/1ps
module tb_multicycle_ctrl;
    localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMREAD = 3,
                   ST_MEMWB = 4, ST_MEMWRITE = 5, ST_EXECR = 6, ST_EXECI = 7,
                   ST_ALUWB = 8, ST_BRANCH = 9;

    typedef struct packed {
        logic [3:0] state;
        logic       pc_write, mem_write, reg_write, ir_write, adr_src, alu_src_a;
        logic [1:0] alu_src_b, result_src, imm_src, reg_src, alu_control;
    } outs_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    bit   rdy = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();
`ifdef CTRL_MEM_WAIT_EN
    assign bus.mem_ready = rdy;
`endif

    multicycle_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    int    checks_total = 0;
    int    checks_passed = 0;
    outs_t exp_o;
    bit    chk_en = 1'b0;
    string cur_tag = "reset";

    // model state
    logic [3:0] m_flags = 4'b0000;
    bit         m_ok = 1'b0;

    // per-instruction observations of the DUT
    int obs_state[16], obs_rw[16], obs_pw[16], obs_mw[16], obs_alu[16], obs_res[16], obs_adr[16];
    int n_obs, nonfetch, lat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic outs_t sample_dut();
        outs_t o;
        o.state       = bus.state_o;
        o.pc_write    = bus.pc_write;
        o.mem_write   = bus.mem_write;
        o.reg_write   = bus.reg_write;
        o.ir_write    = bus.ir_write;
        o.adr_src     = bus.adr_src;
        o.alu_src_a   = bus.alu_src_a;
        o.alu_src_b   = bus.alu_src_b;
        o.result_src  = bus.result_src;
        o.imm_src     = bus.imm_src;
        o.reg_src     = bus.reg_src;
        o.alu_control = bus.alu_control;
        return o;
    endfunction

    // ARM condition as a base predicate on cond[3:1], inverted by cond[0].
    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        if (c == 4'hF) return 1'b0;
        if (c == 4'hE) return 1'b1;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cf;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cf && !z;
            3'd5:    base = (n == v);
            default: base = !z && (n == v);
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic logic [1:0] alu_of(input logic [3:0] cmd);
        case (cmd)
            4'b0010, 4'b1010: return 2'd1;
            4'b0000:          return 2'd2;
            4'b1100:          return 2'd3;
            default:          return 2'd0;
        endcase
    endfunction

    function automatic outs_t expect_outs(input int st, input bit ok, input logic [1:0] op,
                                          input logic [5:0] funct, input logic [3:0] rd, input bit r);
        outs_t o;
        bit    cmp;
        o = '0;
        cmp = (funct[4:1] == 4'b1010);
        o.state = 4'(st);
        o.imm_src = op;
        o.reg_src = {op == 2'b01 && !funct[0], op == 2'b10};
        case (st)
            ST_FETCH:    begin o.ir_write = r; o.pc_write = r; o.alu_src_a = 1; o.alu_src_b = 2; o.result_src = 2; end
            ST_DECODE:   begin o.alu_src_a = 1; o.alu_src_b = 2; o.result_src = 2; end
            ST_MEMADR:   o.alu_src_b = 1;
            ST_MEMREAD:  o.adr_src = 1;
            ST_MEMWB:    begin o.result_src = 1; o.reg_write = ok; o.pc_write = ok && rd == 15; end
            ST_MEMWRITE: begin o.adr_src = 1; o.mem_write = ok && r; end
            ST_EXECR:    o.alu_control = alu_of(funct[4:1]);
            ST_EXECI:    begin o.alu_src_b = 1; o.alu_control = alu_of(funct[4:1]); end
            ST_ALUWB:    begin o.reg_write = ok && !cmp; o.pc_write = ok && !cmp && rd == 15; end
            ST_BRANCH:   begin o.alu_src_b = 1; o.result_src = 2; o.pc_write = ok; end
            default: ;
        endcase
        return o;
    endfunction

    // single compare process
    always @(negedge clk) begin
        if (chk_en) check({cur_tag, " outputs"}, 32'(sample_dut()), 32'(exp_o));
    end

    // One cycle in state st: publish expectation, record DUT, optionally abort via reset.
    task automatic observe(input int st, input bit abort);
        exp_o = expect_outs(st, m_ok, bus.instr_op, bus.instr_funct, bus.instr_rd, rdy);
        chk_en = 1'b1;
        @(negedge clk);
        #1;
        obs_state[n_obs] = int'(bus.state_o);
        obs_rw[n_obs]  = int'(bus.reg_write);
        obs_pw[n_obs]  = int'(bus.pc_write);
        obs_mw[n_obs]  = int'(bus.mem_write);
        obs_alu[n_obs] = int'(bus.alu_control);
        obs_res[n_obs] = int'(bus.result_src);
        obs_adr[n_obs] = int'(bus.adr_src);
        if (bus.state_o != 0) nonfetch++;
        if (n_obs < 15) n_obs++;
        if (abort) begin
            chk_en = 1'b0;
            #1 reset = 1'b0;
            #1;
            check("abort state", 32'(bus.state_o), 32'd0);
            check("abort mem_write", 32'(bus.mem_write), 32'd0);
            check("abort pc_write", 32'(bus.pc_write), 32'd1);
            m_flags = 4'b0000;
            m_ok = 1'b0;
            repeat (2) @(posedge clk);
            #1 reset = 1'b1;
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input string tag, input logic [3:0] cond, input logic [1:0] op,
                       input logic [5:0] funct, input logic [3:0] rd, input logic [3:0] ef,
                       input int stall, input bit abort_mw);
        int seq[$];
        cur_tag = tag;
        seq = {ST_FETCH, ST_DECODE};
        case (op)
            2'b01:   if (funct[0]) seq = {seq, ST_MEMADR, ST_MEMREAD, ST_MEMWB};
                     else          seq = {seq, ST_MEMADR, ST_MEMWRITE};
            2'b00:   seq = {seq, funct[5] ? ST_EXECI : ST_EXECR, ST_ALUWB};
            2'b10:   seq.push_back(ST_BRANCH);
            default: ;
        endcase
        bus.instr_cond = cond;
        bus.instr_op = op;
        bus.instr_funct = funct;
        bus.instr_rd = rd;
        n_obs = 0;
        nonfetch = 0;
        foreach (seq[k]) begin
            int  st;
            bit  exec;
            st = seq[k];
            exec = (st == ST_EXECR || st == ST_EXECI);
            bus.alu_flags = exec ? ef : ~ef;
            if (st == ST_DECODE) m_ok = cond_holds(cond, m_flags);
`ifdef CTRL_MEM_WAIT_EN
            if (st == ST_MEMREAD) begin
                for (int s = 0; s < stall; s++) begin
                    rdy = 1'b0;
                    observe(st, 1'b0);
                end
            end
            rdy = 1'b1;
`endif
            if (abort_mw && st == ST_MEMWRITE) begin
                observe(st, 1'b1);
                break;
            end
            observe(st, 1'b0);
            if (exec && m_ok) begin
                logic [3:0] cmd;
                cmd = funct[4:1];
                if (funct[0] || cmd == 4'b1010) begin
                    if (cmd inside {4'b0100, 4'b0010, 4'b1010}) m_flags = ef;
                    else if (cmd inside {4'b0000, 4'b1100}) m_flags[3:2] = ef[3:2];
                end
            end
        end
        lat = 1 + nonfetch;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.instr_cond = 4'hE; bus.instr_op = 2'b11; bus.instr_funct = '0;
        bus.instr_rd = '0; bus.alu_flags = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset state", 32'(bus.state_o), 32'd0);
        check("reset pc_write", 32'(bus.pc_write), 32'd1);
        check("reset ir_write", 32'(bus.ir_write), 32'd1);
        check("reset mem_write", 32'(bus.mem_write), 32'd0);
        check("reset reg_write", 32'(bus.reg_write), 32'd0);
        reset = 1'b1;

        run("add", 4'hE, 2'b00, 6'b001000, 4'd1, 4'b0000, 0, 0);
        check("add latency", 32'(lat), 32'd4);
        check("add alu_control", 32'(obs_alu[2]), 32'd0);
        check("add reg_write exec", 32'(obs_rw[2]), 32'd0);
        check("add reg_write wb", 32'(obs_rw[3]), 32'd1);

        run("ldr", 4'hE, 2'b01, 6'b011001, 4'd2, 4'b0000, 0, 0);
        check("ldr latency", 32'(lat), 32'd5);
        check("ldr result_src", 32'(obs_res[4]), 32'd1);
        check("ldr reg_write", 32'(obs_rw[4]), 32'd1);

        run("str", 4'hE, 2'b01, 6'b011000, 4'd2, 4'b0000, 0, 0);
        check("str latency", 32'(lat), 32'd4);
        check("str mem_write", 32'(obs_mw[3]), 32'd1);
        check("str adr_src", 32'(obs_adr[3]), 32'd1);

        run("subs", 4'hE, 2'b00, 6'b000101, 4'd0, 4'b0100, 0, 0);
        check("subs alu_control", 32'(obs_alu[2]), 32'd1);
        run("addeq", 4'h0, 2'b00, 6'b001000, 4'd3, 4'b1011, 0, 0);
        check("addeq reg_write", 32'(obs_rw[3]), 32'd1);
        run("addne", 4'h1, 2'b00, 6'b001000, 4'd3, 4'b1011, 0, 0);
        check("addne reg_write", 32'(obs_rw[3]), 32'd0);
        run("addeq again", 4'h0, 2'b00, 6'b001000, 4'd3, 4'b1011, 0, 0);
        check("addeq again reg_write", 32'(obs_rw[3]), 32'd1);

        run("orrs imm", 4'hE, 2'b00, 6'b111001, 4'd4, 4'b1011, 0, 0);
        check("orrs alu_control", 32'(obs_alu[2]), 32'd3);
        run("addcs", 4'h2, 2'b00, 6'b001000, 4'd3, 4'b0000, 0, 0);
        check("addcs reg_write", 32'(obs_rw[3]), 32'd0);
        run("addmi", 4'h4, 2'b00, 6'b001000, 4'd3, 4'b0000, 0, 0);
        check("addmi reg_write", 32'(obs_rw[3]), 32'd1);

        run("adds", 4'hE, 2'b00, 6'b001001, 4'd5, 4'b0011, 0, 0);
        run("addvs", 4'h6, 2'b00, 6'b001000, 4'd3, 4'b0000, 0, 0);
        check("addvs reg_write", 32'(obs_rw[3]), 32'd1);
        run("addhi", 4'h8, 2'b00, 6'b001000, 4'd3, 4'b0000, 0, 0);
        check("addhi reg_write", 32'(obs_rw[3]), 32'd1);

        run("eors unknown", 4'hE, 2'b00, 6'b000011, 4'd6, 4'b0100, 0, 0);
        check("eors alu_control", 32'(obs_alu[2]), 32'd0);
        run("addeq after eors", 4'h0, 2'b00, 6'b001000, 4'd3, 4'b0000, 0, 0);
        check("addeq after eors reg_write", 32'(obs_rw[3]), 32'd0);

        run("cmp", 4'hE, 2'b00, 6'b010100, 4'd0, 4'b0100, 0, 0);
        check("cmp reg_write", 32'(obs_rw[3]), 32'd0);
        run("addeq after cmp", 4'h0, 2'b00, 6'b001000, 4'd3, 4'b0000, 0, 0);
        check("addeq after cmp reg_write", 32'(obs_rw[3]), 32'd1);

        run("b al", 4'hE, 2'b10, 6'b100000, 4'd0, 4'b0000, 0, 0);
        check("b latency", 32'(lat), 32'd3);
        check("b pc_write", 32'(obs_pw[2]), 32'd1);
        run("b nv", 4'hF, 2'b10, 6'b100000, 4'd0, 4'b0000, 0, 0);
        check("b nv pc_write", 32'(obs_pw[2]), 32'd0);

        run("ldr pc", 4'hE, 2'b01, 6'b011001, 4'd15, 4'b0000, 0, 0);
        check("ldr pc pc_write", 32'(obs_pw[4]), 32'd1);
        check("ldr pc reg_write", 32'(obs_rw[4]), 32'd1);

        run("nop", 4'hE, 2'b11, 6'b000000, 4'd0, 4'b0000, 0, 0);
        check("nop latency", 32'(lat), 32'd2);

        run("subs z", 4'hE, 2'b00, 6'b000101, 4'd0, 4'b0100, 0, 0);
        run("streq abort", 4'h0, 2'b01, 6'b011000, 4'd2, 4'b0000, 0, 1);
        run("addeq after reset", 4'h0, 2'b00, 6'b001000, 4'd3, 4'b0000, 0, 0);
        check("addeq after reset reg_write", 32'(obs_rw[3]), 32'd0);
        run("addne after reset", 4'h1, 2'b00, 6'b001000, 4'd3, 4'b0000, 0, 0);
        check("addne after reset reg_write", 32'(obs_rw[3]), 32'd1);

`ifdef CTRL_MEM_WAIT_EN
        run("ldr wait", 4'hE, 2'b01, 6'b011001, 4'd2, 4'b0000, 3, 0);
        check("ldr wait latency", 32'(lat), 32'd8);
        check("ldr wait hold", 32'(obs_state[5]), 32'd3);
`endif

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
